// File: rtl/gray_seq_gen.sv
// Sequential Gray-code source: binary up/down counter with parallel load whose
// registered Gray encoding is offered over a valid/ready handshake.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             rdy,
  output logic [WIDTH-1:0] gray,
  output logic             vld,
  output logic             wrap
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             vld_nxt;
  logic             wrap_nxt;
  logic             xfer;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign xfer = vld & rdy;

  // Load overrides everything; a coincident transfer is still consumed downstream.
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin;
    gray_nxt  = gray;
    vld_nxt   = vld;
    wrap_nxt  = 1'b0;
    if (load) begin
      bin_nxt   = load_val;
      gray_nxt  = bin2gray(load_val);
      vld_nxt   = 1'b0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state_nxt = PRESENT;
            vld_nxt   = 1'b1;
          end
        end
        PRESENT: begin
          if (xfer) begin
            bin_nxt  = dir ? (bin + ONE) : (bin - ONE);
            gray_nxt = bin2gray(bin_nxt);
            wrap_nxt = dir ? (bin == ALL_ONES) : (bin == '0);
            if (!en) begin
              state_nxt = IDLE;
              vld_nxt   = 1'b0;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bin   <= '0;
      gray  <= '0;
      vld   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      bin   <= bin_nxt;
      gray  <= gray_nxt;
      vld   <= vld_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_seq_gen.sv
// Bench for gray_seq_gen: directed vectors, transferred values checked by a
// scoreboard monitor, state/flag values checked directly.
module tb_gray_seq_gen;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             rdy;
  logic [WIDTH-1:0] gray;
  logic             vld;
  logic             wrap;

  int checks;
  int failures;
  logic [WIDTH-1:0] exp_q[$];

  gray_seq_gen #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .rdy      (rdy),
    .gray     (gray),
    .vld      (vld),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer pops the next expected Gray value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vld === 1'b1 && rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected: got %b expected no transfer", gray);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (gray !== e) begin
          failures++;
          $display("FAIL xfer_gray: got %b expected %b", gray, e);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    dir      = 1'b1;
    load     = 1'b0;
    load_val = '0;
    rdy      = 1'b0;

    // Reset state, then hold with en low
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gray", gray, 4'b0000);
    check("rst_vld", vld, 1'b0);
    check("rst_wrap", wrap, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("idle_hold_vld", vld, 1'b0);
    check("idle_hold_gray", gray, 4'b0000);

    // Free run up
    tick();
    en = 1'b1; rdy = 1'b1; dir = 1'b1;
    exp_q.push_back(4'b0000); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0011); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0110); exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0101); exp_q.push_back(4'b0100);
    @(negedge clk);
    check("latency_vld_low", vld, 1'b0);
    repeat (9) tick();
    rdy = 1'b0;
    @(negedge clk);
    check("run_gray_after8", gray, 4'b1100);
    check("run_q_drained", exp_q.size(), 0);

    // Backpressure at 0011
    tick();
    load = 1'b1; load_val = 4'b0010;
    tick();
    load = 1'b0;
    @(negedge clk);
    check("ld_bp_vld", vld, 1'b0);
    check("ld_bp_gray", gray, 4'b0011);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_vld", vld, 1'b1);
      check("stall_gray", gray, 4'b0011);
      tick();
    end
    exp_q.push_back(4'b0011);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    @(negedge clk);
    check("bp_release_gray", gray, 4'b0010);
    check("bp_release_vld", vld, 1'b1);

    // Wrap up from 1111
    tick();
    load = 1'b1; load_val = 4'b1111; en = 1'b0;
    tick();
    load = 1'b0;
    @(negedge clk);
    check("ld_f_gray", gray, 4'b1000);
    check("ld_f_vld", vld, 1'b0);
    check("ld_f_wrap", wrap, 1'b0);
    tick();
    en = 1'b1; rdy = 1'b1;
    exp_q.push_back(4'b1000);
    tick();
    @(negedge clk);
    check("pre_wrap_low", wrap, 1'b0);
    tick();
    rdy = 1'b0;
    @(negedge clk);
    check("wrap_up_gray", gray, 4'b0000);
    check("wrap_up_pulse", wrap, 1'b1);
    tick();
    @(negedge clk);
    check("wrap_up_oneshot", wrap, 1'b0);

    // Wrap down from 0000
    tick();
    dir = 1'b0; rdy = 1'b1;
    exp_q.push_back(4'b0000);
    tick();
    rdy = 1'b0;
    @(negedge clk);
    check("wrap_dn_gray", gray, 4'b1000);
    check("wrap_dn_pulse", wrap, 1'b1);
    tick();
    @(negedge clk);
    check("wrap_dn_oneshot", wrap, 1'b0);

    // Load during stall
    tick();
    dir = 1'b1; load = 1'b1; load_val = 4'b0100;
    tick();
    load = 1'b0;
    tick();
    @(negedge clk);
    check("pre_ld_vld", vld, 1'b1);
    check("pre_ld_gray", gray, 4'b0110);
    tick();
    load = 1'b1; load_val = 4'b0101;
    tick();
    load = 1'b0;
    @(negedge clk);
    check("ld_stall_vld", vld, 1'b0);
    check("ld_stall_gray", gray, 4'b0111);
    tick();
    @(negedge clk);
    check("ld_stall_revld", vld, 1'b1);
    check("ld_stall_regray", gray, 4'b0111);

    // Load coincident with transfer
    tick();
    rdy = 1'b1; load = 1'b1; load_val = 4'b0000;
    exp_q.push_back(4'b0111);
    tick();
    load = 1'b0; rdy = 1'b0; en = 1'b0;
    @(negedge clk);
    check("ld_xfer_gray", gray, 4'b0000);
    check("ld_xfer_vld", vld, 1'b0);
    check("ld_xfer_wrap", wrap, 1'b0);

    // Stop at transfer of 0010
    tick();
    load = 1'b1; load_val = 4'b0011;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    en = 1'b0; rdy = 1'b1;
    exp_q.push_back(4'b0010);
    tick();
    en = 1'b1; rdy = 1'b0;
    @(negedge clk);
    check("stop_vld", vld, 1'b0);
    check("stop_gray", gray, 4'b0110);
    tick();
    @(negedge clk);
    check("restart_vld", vld, 1'b1);
    check("restart_gray", gray, 4'b0110);

    // Asynchronous reset mid-operation
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gray", gray, 4'b0000);
    check("async_rst_vld", vld, 1'b0);
    check("async_rst_wrap", wrap, 1'b0);
    check("q_empty_end", exp_q.size(), 0);
    exp_q.delete();
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_vld", vld, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_seq_gen.md
Name: gray_seq_gen

Overview:
- Sequential Gray-code source. Feeds the gray-to-binary converter stage directly downstream.
- Holds an internal binary count and presents its Gray encoding over a valid/ready handshake.
- Counts up or down, supports parallel load, and flags wrap-around.
- Guarantees consecutive accepted outputs differ in exactly one bit, except across a load.

Parameters:
WIDTH, 4, bit width of the count and of the Gray output.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  enable; request to present/advance values.
dir  input  1  1 = count up, 0 = count down; sampled at each transfer.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  binary value loaded into the count.
rdy  input  1  downstream ready.
gray  output  WIDTH  registered Gray code of the current count.
vld  output  1  gray is valid for transfer.
wrap  output  1  one-cycle pulse on count wrap-around.

Behaviour:
- Reset is asynchronous on rst_n low, with synchronous deassertion handled at system level. While reset is asserted:
  - bin = 0, gray = 0, vld = 0, wrap = 0, state = IDLE.
- Internal register bin[WIDTH-1:0]. gray is always registered as the encoding of bin, never combinational from bin:
  - gray = next_bin ^ (next_bin >> 1)
- A transfer occurs in a cycle where vld & rdy = 1 at the clock edge.
- States:
  - IDLE: vld = 0; gray holds the encoding of bin. If en = 1 and load = 0: vld <= 1 and go to PRESENT. Latency from en to vld is 1 cycle.
  - PRESENT: vld = 1. If rdy = 0: gray and bin hold (no change while stalled). On transfer, bin advances per dir:
    - up: bin + 1 mod 2^WIDTH
    - down: bin - 1 mod 2^WIDTH
    - gray updates on the same edge.
    - If en = 1 at transfer: stay in PRESENT with vld = 1, so back-to-back transfers give one value per cycle.
    - If en = 0 at transfer: go to IDLE with vld = 0. The count is still advanced.
  - In PRESENT, en = 0 without a transfer has no effect; an offered value is never withdrawn.
- load = 1, any state, highest priority:
  - bin <= load_val, gray <= encoding of load_val, vld <= 0, state <= IDLE. No wrap pulse.
  - If a transfer coincides with load, the transfer completes (downstream has consumed the old gray) and the loaded value replaces the advanced value.
  - en is ignored in the load cycle; vld can reassert the following cycle.
- wrap:
  - Registered; high for exactly the cycle after a transfer that moved bin from all-ones to 0 (up) or from 0 to all-ones (down).
  - Otherwise 0. A load of 0 or all-ones never pulses wrap.
- dir changes take effect at the next transfer only.
- Reset mid-operation: all outputs go to their reset values immediately, without waiting for clk. Any pending value is discarded.

Test Plan:
1. Reset: assert rst_n = 0 between clock edges -> gray = 0000, vld = 0, wrap = 0 immediately. Release, en = 0 -> outputs hold.
2. Free run (WIDTH = 4): en = 1, dir = 1, rdy = 1 -> vld rises 1 cycle after en. gray sequence is 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, one per cycle, each step a single-bit change.
3. Backpressure: at gray = 0011, hold rdy = 0 for 3 cycles -> gray = 0011 and vld = 1 stable. rdy = 1 -> next cycle gray = 0010.
4. Wrap, up: load = 1 with load_val = 1111 -> gray = 1000, vld = 0, wrap = 0. Then en = 1, rdy = 1 -> transfer of 1000, then gray = 0000 with wrap = 1 for one cycle only.
   Wrap, down: dir = 0 starting from 0000 -> transfer gives gray = 1000 and a wrap pulse.
5. Load during stall: vld = 1, rdy = 0, gray = 0110; load = 1 with load_val = 0101 -> next cycle vld = 0, gray = 0111. en = 1 -> vld = 1 the following cycle with gray = 0111.
   Load coincident with transfer: load and transfer in the same cycle -> loaded value wins, no advance, no wrap.
6. Stop: en = 0 at a transfer of 0010 -> next cycle vld = 0, gray = 0110 (advanced). en = 1 -> vld = 1 and gray = 0110 is presented again.
